multi_actuator_driver: RTL and testbench
========================================

# multi_actuator_driver

Parametrised N-channel actuator driver, the next generation of `actuator_driver_controller` inside `user_project_wrapper`. Each channel drives one H-bridge leg pair (`drv_p`/`drv_n`) from queued-one-deep pulse commands. Every pulse gets programmable dead-time insertion before it. The block supports per-channel abort, a global enable, and sticky per-channel completion flags that are OR-ed into an interrupt. Commands arrive over a valid/ready port fed from the logic analyzer or Wishbone register bank, and driver outputs go to `io_out`.

## Interface
- `NUM_CH`, 8: number of actuator channels (1..32).
- `CNT_W`, 16: width of the pulse-length counter.
- `DEAD_W`, 4: width of the dead-time counter.
- `CH_W`, `$clog2(NUM_CH)` (min 1): channel index width. Derived; not for override.

Ports:
- `wb_clk_i` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: global enable. Low aborts all channels.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accept.
- `cmd_ch` in CH_W: target channel.
- `cmd_dir` in 1: 1 drives `drv_p`, 0 drives `drv_n`.
- `cmd_len` in CNT_W: drive length in cycles.
- `dead_time` in DEAD_W: dead-time cycles. Sampled at accept.
- `cmd_abort` in 1: abort channel `cmd_ch`.
- `done_clr` in NUM_CH: per-channel done-flag clear, one-cycle strobes.
- `drv_p` out NUM_CH: positive leg drive.
- `drv_n` out NUM_CH: negative leg drive.
- `busy` out NUM_CH: channel not idle.
- `done` out NUM_CH: sticky completion flags.
- `irq` out 1: OR of `done`.

## Operation
- Each channel has its own FSM with states IDLE, DEAD and DRIVE.
- `cmd_ready = enable & ~cmd_abort & ~busy[cmd_ch]`. This is combinational.
- `cmd_ch >= NUM_CH`: `cmd_ready = 0`.
- Accept happens when `cmd_valid & cmd_ready`. At that edge the channel latches `dir`, `len` and `dead_time`.
  - If `dead_time != 0`: enter DEAD.
  - Else if `len != 0`: enter DRIVE.
  - Else (both zero): stay IDLE and set `done` at the accept edge.
- DEAD: both legs low. The counter loads `dead_time` and decrements each cycle. When it reaches 1:
  - if `len != 0`, go to DRIVE;
  - else go to IDLE and set `done`.
- DRIVE: the leg selected by `dir` is high and the other is low. The counter loads `len` and decrements. When it reaches 1, go to IDLE and set `done`.
- `drv_p[i] & drv_n[i]` is never 1 in any cycle. Both outputs are registered, decoded from state.
- `busy[i] = (state != IDLE)`. Registered.
- Abort: if `cmd_abort` is set and `cmd_ch` is in range, that channel goes to IDLE at the next edge, drivers go low, and `done` is not set. Abort on an IDLE channel has no effect.
- `enable = 0`: all channels go to IDLE at the next edge with no `done`. Commands are refused.
- `done[i]`:
  - set on normal completion;
  - cleared by `done_clr[i]`;
  - if set and clear occur on the same edge, set wins.
- `irq = |done`. Registered.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): all FSMs IDLE, and `drv_p`, `drv_n`, `busy`, `done` and `irq` all 0. `cmd_ready` follows its equation using `busy = 0`.
- Reset asserted mid-pulse: drivers drop asynchronously. No `done` is set.
- Accept at edge E0 with dead time D > 0 and length L > 0:
  - `busy = 1` after E0;
  - the leg is high after edge E(D) through E(D+L−1);
  - after E(D+L) the leg is low, `busy = 0` and `done = 1`;
  - `irq = 1` after E(D+L+1).
- D = 0, L > 0: the leg is high after E0 through E(L−1). Low and `done` after E(L).
- A channel can accept a new command on the cycle after `busy` falls. There is no back-to-back overlap within a channel.
- Channels run fully independently. Only one command is accepted per cycle.
- The maximum pulse is 2^CNT_W − 1 cycles. The counter never wraps.

## Test plan
- Reset, then on ch0 `dir = 1`, `len = 3`, `dead_time = 2` → `drv_p[0]` high for exactly 3 cycles starting 2 cycles after accept. `drv_n[0]` stays 0. `done[0]` is set and `irq` rises one cycle later.
- On ch2 `dir = 0`, `len = 0`, `dead_time = 0` → no drive. `done[2]` is set at the accept edge. `busy[2]` never rises.
- Start ch1 with `len = 100`. At cycle 10, assert `cmd_abort` with `cmd_ch = 1` → drivers low next cycle, `busy[1] = 0`, `done[1] = 0`. `cmd_ready` is low during the abort cycle.
- Run ch0 and ch7 simultaneously. Retry ch0 while it is busy → `cmd_ready = 0`. Drop `enable` mid-pulse → all drivers low next cycle, no `done`.
- Assert `done_clr[3]` on the same edge as ch3 completes → `done[3]` stays 1. A later `done_clr[3]` clears it and `irq` falls.
- Random command/abort/clear stress over all channels → `drv_p & drv_n` is never 1, and pulse widths and dead times match the scoreboard.

Source files
------------

// File: rtl/multi_actuator_driver.sv
// N-channel H-bridge actuator driver. Each channel takes one pulse command,
// waits out a programmable dead time with both legs low, drives one leg for the
// commanded length, then raises a sticky done flag. All done flags are OR-ed
// into a registered interrupt. Channels run independently of each other.
module multi_actuator_driver #(
  parameter  int NUM_CH = 8,
  parameter  int CNT_W  = 16,
  parameter  int DEAD_W = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic              cmd_abort,
  input  logic [NUM_CH-1:0] done_clr,
  output logic [NUM_CH-1:0] drv_p,
  output logic [NUM_CH-1:0] drv_n,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DEAD  = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [CNT_W-1:0]   len_q   [NUM_CH];
  logic [CNT_W-1:0]   len_d   [NUM_CH];
  logic [NUM_CH-1:0]  dir_q, dir_d;
  logic [NUM_CH-1:0]  drv_p_q, drv_p_d;
  logic [NUM_CH-1:0]  drv_n_q, drv_n_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic               irq_q;

  logic [NUM_CH-1:0]  ch_sel;
  logic [NUM_CH-1:0]  done_set;
  logic [31:0]        ch_ext;
  logic               ch_valid;
  logic               accept;

  // Decode the command channel one-hot; out-of-range indices select nothing.
  always_comb begin
    ch_ext   = 32'(cmd_ch);
    ch_valid = (ch_ext < 32'(NUM_CH));
    ch_sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = ch_valid && (cmd_ch == CH_W'(i));
    end
  end

  // A channel accepts only when globally enabled, not being aborted and idle.
  assign cmd_ready = enable & ~cmd_abort & ch_valid & ~(|(ch_sel & busy_q));
  assign accept    = cmd_valid & cmd_ready;

  // Per-channel next-state logic; outputs are decoded from the next state so
  // they register in step with the state itself.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every variable gets a default before any branch, so no path
      // through this block can leave a value held and infer a latch.
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      len_d[i]    = len_q[i];
      dir_d[i]    = dir_q[i];
      done_set[i] = 1'b0;

      if (!enable || (cmd_abort && ch_sel[i])) begin
        // Global disable or abort: drop to idle with no completion.
        state_d[i] = S_IDLE;
      end else begin
        unique case (state_q[i])
          S_IDLE: begin
            if (accept && ch_sel[i]) begin
              dir_d[i] = cmd_dir;
              len_d[i] = cmd_len;
              if (dead_time != '0) begin
                state_d[i] = S_DEAD;
                cnt_d[i]   = CNT_W'(dead_time);
              end else if (cmd_len != '0) begin
                state_d[i] = S_DRIVE;
                cnt_d[i]   = cmd_len;
              end else begin
                done_set[i] = 1'b1;
              end
            end
          end
          S_DEAD: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              if (len_q[i] != '0) begin
                state_d[i] = S_DRIVE;
                cnt_d[i]   = len_q[i];
              end else begin
                state_d[i]  = S_IDLE;
                done_set[i] = 1'b1;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          S_DRIVE: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i]  = S_IDLE;
              done_set[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end

      drv_p_d[i] = (state_d[i] == S_DRIVE) &&  dir_d[i];
      drv_n_d[i] = (state_d[i] == S_DRIVE) && !dir_d[i];
      busy_d[i]  = (state_d[i] != S_IDLE);
    end
    // A completion on the same edge as a clear keeps the flag set.
    done_d = (done_q & ~done_clr) | done_set;
  end

  // State, counters and registered outputs; reset drops the drivers at once.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-channel arrays are a handful of control flops, not a
      // RAM, so they are reset along with everything else.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        len_q[i]   <= '0;
      end
      dir_q   <= '0;
      drv_p_q <= '0;
      drv_n_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      drv_p_q <= drv_p_d;
      drv_n_q <= drv_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      irq_q   <= |done_q;
    end
  end

  assign drv_p = drv_p_q;
  assign drv_n = drv_n_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_multi_actuator_driver.sv
// Testbench for multi_actuator_driver: directed vector table with hand-computed
// expectations, a mid-pulse reset sequence, and a randomized stress phase
// checked against a pulse-timeline scoreboard.
module tb_multi_actuator_driver;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 16;
  localparam int DEAD_W = 4;
  localparam int CH_W   = 3;

  logic              wb_clk_i  = 1'b0;
  logic              rst_n     = 1'b0;
  logic              enable    = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch    = '0;
  logic              cmd_dir   = 1'b0;
  logic [CNT_W-1:0]  cmd_len   = '0;
  logic [DEAD_W-1:0] dead_time = '0;
  logic              cmd_abort = 1'b0;
  logic [NUM_CH-1:0] done_clr  = '0;
  logic [NUM_CH-1:0] drv_p, drv_n, busy, done;
  logic              irq;

  multi_actuator_driver #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEAD_W(DEAD_W)) dut (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .enable   (enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch   (cmd_ch),
    .cmd_dir  (cmd_dir),
    .cmd_len  (cmd_len),
    .dead_time(dead_time),
    .cmd_abort(cmd_abort),
    .done_clr (done_clr),
    .drv_p    (drv_p),
    .drv_n    (drv_n),
    .busy     (busy),
    .done     (done),
    .irq      (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en, valid, dir, abort;
    logic [2:0]  ch;
    logic [15:0] len;
    logic [3:0]  dt;
    logic [7:0]  clr;
    logic        exp_ready;
    logic [7:0]  exp_p, exp_n, exp_busy, exp_done;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, valid, input logic [2:0] ch, input logic dir,
                              input logic [15:0] len, input logic [3:0] dt, input logic abort,
                              input logic [7:0] clr, input logic rdy,
                              input logic [7:0] p, n, b, d, input logic irq_e);
    vec_t v;
    v.en = en; v.valid = valid; v.ch = ch; v.dir = dir; v.len = len; v.dt = dt;
    v.abort = abort; v.clr = clr; v.exp_ready = rdy;
    v.exp_p = p; v.exp_n = n; v.exp_busy = b; v.exp_done = d; v.exp_irq = irq_e;
    vecs.push_back(v);
  endfunction

  // Drive one vector before an edge, check ready, then check registered outputs.
  task automatic apply(input vec_t v, input int idx);
    @(negedge wb_clk_i);
    enable = v.en; cmd_valid = v.valid; cmd_ch = v.ch; cmd_dir = v.dir;
    cmd_len = v.len; dead_time = v.dt; cmd_abort = v.abort; done_clr = v.clr;
    #1 check($sformatf("v%0d ready", idx), 32'(cmd_ready), 32'(v.exp_ready));
    @(posedge wb_clk_i);
    #1;
    check($sformatf("v%0d drv_p", idx), 32'(drv_p), 32'(v.exp_p));
    check($sformatf("v%0d drv_n", idx), 32'(drv_n), 32'(v.exp_n));
    check($sformatf("v%0d busy", idx),  32'(busy),  32'(v.exp_busy));
    check($sformatf("v%0d done", idx),  32'(done),  32'(v.exp_done));
    check($sformatf("v%0d irq", idx),   32'(irq),   32'(v.exp_irq));
  endtask

  // Scoreboard: each channel tracks cycles since accept against D and L.
  bit         m_act [NUM_CH];
  bit         m_dir [NUM_CH];
  int         m_k   [NUM_CH];
  int         m_d   [NUM_CH];
  int         m_l   [NUM_CH];
  logic [7:0] m_done;
  logic       m_irq;

  initial begin
    // Sequence A: ch0 dir=1 len=3 dead=2
    add(1,1,0,1,3,2,0,8'h00, 1, 8'h00,8'h00,8'h01,8'h00,0);
    add(1,0,0,0,0,0,0,8'h00, 0, 8'h00,8'h00,8'h01,8'h00,0);
    add(1,0,0,0,0,0,0,8'h00, 0, 8'h01,8'h00,8'h01,8'h00,0);
    add(1,0,0,0,0,0,0,8'h00, 0, 8'h01,8'h00,8'h01,8'h00,0);
    add(1,0,0,0,0,0,0,8'h00, 0, 8'h01,8'h00,8'h01,8'h00,0);
    add(1,0,0,0,0,0,0,8'h00, 0, 8'h00,8'h00,8'h00,8'h01,0);
    add(1,0,0,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h01,1);
    add(1,0,0,0,0,0,0,8'h01, 1, 8'h00,8'h00,8'h00,8'h00,1);
    add(1,0,0,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h00,0);
    // Sequence B: ch2 zero length, zero dead time
    add(1,1,2,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h04,0);
    add(1,0,2,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h04,1);
    add(1,0,2,0,0,0,0,8'h04, 1, 8'h00,8'h00,8'h00,8'h00,1);
    add(1,0,2,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h00,0);
    // Sequence C: ch1 len=100, abort at cycle 10 (with a retry that must be refused)
    add(1,1,1,0,100,0,0,8'h00, 1, 8'h00,8'h02,8'h02,8'h00,0);
    for (int k = 0; k < 9; k++)
      add(1,0,1,0,0,0,0,8'h00, 0, 8'h00,8'h02,8'h02,8'h00,0);
    add(1,1,1,0,5,0,1,8'h00, 0, 8'h00,8'h00,8'h00,8'h00,0);
    add(1,0,1,0,0,0,1,8'h00, 0, 8'h00,8'h00,8'h00,8'h00,0);
    // Sequence D: ch0 and ch7 together, busy retry, enable drop mid-pulse
    add(1,1,0,1,20,1,0,8'h00, 1, 8'h00,8'h00,8'h01,8'h00,0);
    add(1,1,7,0,20,0,0,8'h00, 1, 8'h01,8'h80,8'h81,8'h00,0);
    add(1,1,0,1,5,0,0,8'h00,  0, 8'h01,8'h80,8'h81,8'h00,0);
    add(0,1,7,0,5,0,0,8'h00,  0, 8'h00,8'h00,8'h00,8'h00,0);
    add(1,0,0,0,0,0,0,8'h00,  1, 8'h00,8'h00,8'h00,8'h00,0);
    // Sequence E: clear on the completion edge of ch3, then a later clear
    add(1,1,3,1,2,0,0,8'h00, 1, 8'h08,8'h00,8'h08,8'h00,0);
    add(1,0,3,0,0,0,0,8'h00, 0, 8'h08,8'h00,8'h08,8'h00,0);
    add(1,0,3,0,0,0,0,8'h08, 0, 8'h00,8'h00,8'h00,8'h08,0);
    add(1,0,3,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h08,1);
    add(1,0,3,0,0,0,0,8'h08, 1, 8'h00,8'h00,8'h00,8'h00,1);
    add(1,0,3,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h00,0);
    // Sequence F: ch5 dead time only (len=0, dead=3)
    add(1,1,5,1,0,3,0,8'h00, 1, 8'h00,8'h00,8'h20,8'h00,0);
    add(1,0,5,0,0,0,0,8'h00, 0, 8'h00,8'h00,8'h20,8'h00,0);
    add(1,0,5,0,0,0,0,8'h00, 0, 8'h00,8'h00,8'h20,8'h00,0);
    add(1,0,5,0,0,0,0,8'h00, 0, 8'h00,8'h00,8'h00,8'h20,0);
    add(1,0,5,0,0,0,0,8'h20, 1, 8'h00,8'h00,8'h00,8'h00,1);
    add(1,0,5,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h00,0);
    // Sequence G: commands refused while disabled
    add(0,1,4,1,5,0,0,8'h00, 0, 8'h00,8'h00,8'h00,8'h00,0);
    // Sequence H: ch6 shortest pulse, len=1 dead=1
    add(1,1,6,0,1,1,0,8'h00, 1, 8'h00,8'h00,8'h40,8'h00,0);
    add(1,0,6,0,0,0,0,8'h00, 0, 8'h00,8'h40,8'h40,8'h00,0);
    add(1,0,6,0,0,0,0,8'h00, 0, 8'h00,8'h00,8'h00,8'h40,0);
    add(1,0,6,0,0,0,0,8'h40, 1, 8'h00,8'h00,8'h00,8'h00,1);
    add(1,0,6,0,0,0,0,8'h00, 1, 8'h00,8'h00,8'h00,8'h00,0);

    // Reset state
    enable = 1'b1;
    #12;
    check("reset ready", 32'(cmd_ready), 32'd1);
    check("reset drv_p", 32'(drv_p), 32'd0);
    check("reset drv_n", 32'(drv_n), 32'd0);
    check("reset busy",  32'(busy),  32'd0);
    check("reset done",  32'(done),  32'd0);
    check("reset irq",   32'(irq),   32'd0);
    @(negedge wb_clk_i);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset asserted mid-pulse: drivers and busy drop without a clock edge.
    @(negedge wb_clk_i);
    enable = 1'b1; cmd_valid = 1'b1; cmd_ch = 3'd2; cmd_dir = 1'b1;
    cmd_len = 16'd10; dead_time = 4'd0; cmd_abort = 1'b0; done_clr = '0;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #2 check("pre-reset drv_p", 32'(drv_p), 32'h04);
    rst_n = 1'b0;
    #1;
    check("mid-reset drv_p", 32'(drv_p), 32'd0);
    check("mid-reset busy",  32'(busy),  32'd0);
    check("mid-reset done",  32'(done),  32'd0);
    @(negedge wb_clk_i);
    rst_n = 1'b1;

    // Randomized stress against the timeline scoreboard.
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = 0; m_dir[i] = 0; m_k[i] = 0; m_d[i] = 0; m_l[i] = 0;
    end
    m_done = '0;
    m_irq  = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic       exp_ready;
      logic [7:0] set_v, exp_p, exp_n, exp_b;
      logic       next_irq;
      @(negedge wb_clk_i);
      enable    = ($urandom_range(0, 49) != 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_ch    = 3'($urandom_range(0, 7));
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_len   = 16'($urandom_range(0, 6));
      dead_time = 4'($urandom_range(0, 3));
      cmd_abort = ($urandom_range(0, 15) == 0);
      done_clr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      exp_ready = enable && !cmd_abort && !m_act[int'(cmd_ch)];
      #1 check($sformatf("stress%0d ready", cyc), 32'(cmd_ready), 32'(exp_ready));

      set_v    = '0;
      next_irq = |m_done;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable || (cmd_abort && int'(cmd_ch) == i)) begin
          m_act[i] = 0;
        end else if (cmd_valid && exp_ready && int'(cmd_ch) == i) begin
          if (dead_time == 0 && cmd_len == 0) begin
            set_v[i] = 1'b1;
          end else begin
            m_act[i] = 1; m_k[i] = 0; m_dir[i] = cmd_dir;
            m_d[i] = int'(dead_time); m_l[i] = int'(cmd_len);
          end
        end else if (m_act[i]) begin
          m_k[i]++;
          if (m_k[i] == m_d[i] + m_l[i]) begin
            m_act[i] = 0;
            set_v[i] = 1'b1;
          end
        end
      end
      m_done = (m_done & ~done_clr) | set_v;
      m_irq  = next_irq;
      for (int i = 0; i < NUM_CH; i++) begin
        exp_b[i] = m_act[i];
        exp_p[i] = m_act[i] && (m_k[i] >= m_d[i]) &&  m_dir[i];
        exp_n[i] = m_act[i] && (m_k[i] >= m_d[i]) && !m_dir[i];
      end

      @(posedge wb_clk_i);
      #1;
      check($sformatf("stress%0d overlap", cyc), 32'(drv_p & drv_n), 32'd0);
      check($sformatf("stress%0d drv_p", cyc), 32'(drv_p), 32'(exp_p));
      check($sformatf("stress%0d drv_n", cyc), 32'(drv_n), 32'(exp_n));
      check($sformatf("stress%0d busy", cyc),  32'(busy),  32'(exp_b));
      check($sformatf("stress%0d done", cyc),  32'(done),  32'(m_done));
      check($sformatf("stress%0d irq", cyc),   32'(irq),   32'(m_irq));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
